reser_sad_chroma: RTL and testbench
===================================

# reser_sad_chroma

Parametrised, streaming successor to the fixed 8x8 chroma residual stage. It accepts one block row per beat, together with the same row from each of `NMODES` intra predictions. For every mode it emits a signed, non-wrapping residual row. It also accumulates a per-mode SAD over the block and reports the lowest-cost mode on the block's last beat. It sits between the chroma predictor bank and the transform/mode-decision stage, with valid/ready flow control on both sides.

## Interface
Parameters:
- `BLK`, 8: block edge in pixels (4, 8 or 16); one row of `BLK` pixels per beat, `BLK` beats per block.
- `W`, 8: pixel width.
- `NMODES`, 4: number of candidate predictions (index 0 = V, 1 = H, 2 = DC, 3 = Plane).
- `SADW`, `W + 2*$clog2(BLK)`: SAD accumulator width; must not be overridden smaller.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `in_valid`, in, 1: input row valid.
- `in_ready`, out, 1: block can accept a row.
- `mb_row`, in, `BLK*W`: source pixels of the current row, unsigned.
- `pred_row`, in, `NMODES*BLK*W`: prediction rows, mode-major, unsigned.
- `out_valid`, out, 1: residual row valid.
- `out_ready`, in, 1: downstream accepts the row.
- `out_row`, out, `NMODES*BLK*(W+1)`: signed residuals, two's complement, equal to mb minus pred.
- `out_idx`, out, `$clog2(BLK)`: row index within the block.
- `out_last`, out, 1: high when `out_idx == BLK-1`.
- `sad`, out, `NMODES*SADW`: per-mode block SAD; meaningful only while `out_valid && out_last`.
- `best_mode`, out, `$clog2(NMODES)`: index of the minimum SAD; meaningful under the same qualifier.

## Operation
- An input beat is accepted on `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is a single register stage with no skid buffer.
- On accept:
  - Residual: each `out_row` element is computed as `{1'b0,mb} - {1'b0,pred}` at `W+1` bits. There is no wrap and no clipping; the range is -(2^W-1) to 2^W-1.
  - Row SAD: for each mode, the sum of |residual| across the `BLK` lanes.
  - Row counter `row_cnt` (0 to `BLK-1`) is registered into `out_idx`, then increments and wraps to 0 after `BLK-1`.
- Accumulation, when the accepted row is not the last: `acc[m] <= acc[m] + row_sad[m]`.
- On the last row (`row_cnt == BLK-1`):
  - `sad[m] <= acc[m] + row_sad[m]`.
  - `acc` clears to 0 in the same cycle.
  - `best_mode` is registered from the new SAD values: strict minimum, ties resolve to the lowest index.
- `sad` and `best_mode` hold their values until the next last-row accept.
- There is no block-start input; block boundaries come only from `row_cnt`.
- FSM states:
  - IDLE: `out_valid=0`.
  - FULL: `out_valid=1`.
  - IDLE→FULL on accept.
  - FULL→IDLE on `out_ready && !in_valid`.
  - FULL→FULL on `out_ready && in_valid` (back-to-back beat), or on `!out_ready` (hold).
- While `out_valid && !out_ready`, all outputs are stable and `in_ready=0`.

## Timing
- Latency: a row accepted at edge N appears with `out_valid=1` after edge N.
- Throughput: one row per cycle when `out_ready` is held high; a full block takes `BLK` cycles.
- The SAD/best_mode result arrives on the same beat as the block's last residual row, 1 cycle after the last input is accepted.
- Reset value of every output and state element while `reset=0`:
  - `out_valid=0`, `out_row=0`, `out_idx=0`, `out_last=0`.
  - `sad=0`, `best_mode=0`.
  - `acc=0`, `row_cnt=0`.
  - `in_ready` is 1 (combinational).
- Reset in mid-block discards the partial block. The next accepted row is row 0 of a new block.
- A pending output that is not yet accepted at reset is dropped.

## Structure
- Package `intra_pkg`:
  - mode constants `MODE_V=0`, `MODE_H=1`, `MODE_DC=2`, `MODE_PLANE=3`;
  - function `sadw(blk,w)`;
  - the packed row typedef helpers.
- Sub-module `row_sad`: `BLK` absolute values feeding an adder tree that produces `W+$clog2(BLK)` bits. It is purely combinational and is instantiated once per mode.
- The top level holds the counter, accumulators, output register, min-select and handshake.

## Test plan
- Reset: hold `reset=0`, drive random inputs → all outputs 0, `in_ready=1`; after release, the first accepted row has `out_idx=0`.
- Full-rate block (`BLK=8`, `W=8`), `mb`=200 everywhere, V=200, H=190, DC=210, Plane=0:
  - residuals per beat are 0, +10, -10, +200;
  - on the 8th output beat, `out_last=1`, `sad`={0, 640, 640, 12800} and `best_mode=0`.
- Extremes: `mb`=0 with pred=255 → residual 9'h101 (-255); `mb`=255 with pred=0 → 9'h0FF. With all lanes at 255 vs 0 for 8 rows, `sad`=16320 with no overflow.
- Tie-break: V and H SAD both 100, DC 100, Plane 300 → `best_mode=0`. Changing DC to 99 → `best_mode=2`.
- Backpressure: drop `out_ready` for 3 cycles at row 3 → `in_ready=0` and `out_row` stable for those cycles; all 8 rows are delivered in order and SADs match the unstalled run.
- Mid-block reset: assert `reset` after row 4 is accepted, then stream a full block of `mb`=10, pred=0 → `sad[V]`=640, `out_idx` sequence 0..7, with no contribution from the aborted rows.

Source files
------------

// File: rtl/reser_sad_chroma_pkg.sv
// Shared constants and helpers for the chroma residual / SAD mode-decision stage.
package intra_pkg;

    localparam int MODE_V     = 0;
    localparam int MODE_H     = 1;
    localparam int MODE_DC    = 2;
    localparam int MODE_PLANE = 3;

    typedef enum logic {
        ST_IDLE,
        ST_FULL
    } state_t;

    // Block SAD width: every lane of every row at full scale must fit.
    function automatic int sadw(input int blk, input int w);
        return w + 2 * $clog2(blk);
    endfunction

    function automatic int row_bits(input int lanes, input int w);
        return lanes * w;
    endfunction

endpackage

// File: rtl/reser_sad_chroma_row_sad.sv
// Sum of absolute residuals across one row of one prediction mode (combinational).
module row_sad
    import intra_pkg::*;
#(
    parameter int BLK = 8,
    parameter int W   = 8
) (
    input  logic [row_bits(BLK, W+1)-1:0] i_res,
    output logic [W+$clog2(BLK)-1:0]      o_sad
);

    localparam int OW = W + $clog2(BLK);

    logic signed [W:0] w_lane;
    logic [W-1:0]      w_abs;
    logic [OW-1:0]     w_sum;

    // |r| of a W+1-bit residual never exceeds 2^W-1, so W bits hold it exactly.
    always_comb begin
        w_lane = '0;
        w_abs  = '0;
        w_sum  = '0;
        for (int l = 0; l < BLK; l++) begin
            w_lane = signed'(i_res[l*(W+1) +: W+1]);
            w_abs  = w_lane[W] ? W'(-w_lane) : w_lane[W-1:0];
            w_sum  = w_sum + OW'(w_abs);
        end
    end

    assign o_sad = w_sum;

endmodule

// File: rtl/reser_sad_chroma.sv
// Streaming chroma residual stage: per-mode residual rows, block SAD and best-mode pick.
module reser_sad_chroma
    import intra_pkg::*;
#(
    parameter int BLK    = 8,
    parameter int W      = 8,
    parameter int NMODES = 4,
    parameter int SADW   = sadw(BLK, W)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BLK*W-1:0]                mb_row,
    input  logic [NMODES*BLK*W-1:0]         pred_row,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NMODES*BLK*(W+1)-1:0]     out_row,
    output logic [$clog2(BLK)-1:0]          out_idx,
    output logic                            out_last,
    output logic [NMODES*SADW-1:0]          sad,
    output logic [$clog2(NMODES)-1:0]       best_mode
);

    localparam int IW  = $clog2(BLK);
    localparam int MW  = $clog2(NMODES);
    localparam int RW  = W + IW;
    localparam int RSW = W + 1;
    localparam int ROWW = BLK * RSW;

    state_t                   r_state;
    state_t                   w_next;
    logic [IW-1:0]            r_row_cnt;
    logic [SADW-1:0]          r_acc [NMODES];
    logic [NMODES*ROWW-1:0]   r_out_row;
    logic [IW-1:0]            r_out_idx;
    logic                     r_out_last;
    logic [NMODES*SADW-1:0]   r_sad;
    logic [MW-1:0]            r_best;

    logic [NMODES*ROWW-1:0]   w_res;
    logic [RW-1:0]            w_row_sad [NMODES];
    logic [SADW-1:0]          w_new_sad [NMODES];
    logic [SADW-1:0]          w_min;
    logic [MW-1:0]            w_best;
    logic                     w_accept;
    logic                     w_last;

    // Zero-extended subtraction keeps the full -(2^W-1)..2^W-1 range without wrap.
    for (genvar m = 0; m < NMODES; m++) begin : g_mode
        for (genvar l = 0; l < BLK; l++) begin : g_lane
            assign w_res[(m*BLK+l)*RSW +: RSW] =
                {1'b0, mb_row[l*W +: W]} - {1'b0, pred_row[(m*BLK+l)*W +: W]};
        end

        row_sad #(.BLK(BLK), .W(W)) u_row_sad (
            .i_res (w_res[m*ROWW +: ROWW]),
            .o_sad (w_row_sad[m])
        );

        assign w_new_sad[m] = r_acc[m] + SADW'(w_row_sad[m]);
    end

    // Strict less-than scan so ties keep the lowest mode index.
    always_comb begin
        w_min  = w_new_sad[0];
        w_best = '0;
        for (int m = 1; m < NMODES; m++) begin
            if (w_new_sad[m] < w_min) begin
                w_min  = w_new_sad[m];
                w_best = MW'(m);
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_row_cnt == IW'(BLK - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_FULL;
            ST_FULL: if (out_ready && !in_valid) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_row_cnt  <= '0;
            r_out_row  <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
            r_sad      <= '0;
            r_best     <= '0;
            for (int m = 0; m < NMODES; m++) r_acc[m] <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_out_row  <= w_res;
                r_out_idx  <= r_row_cnt;
                r_out_last <= w_last;
                r_row_cnt  <= w_last ? '0 : r_row_cnt + IW'(1);
                for (int m = 0; m < NMODES; m++) begin
                    if (w_last) begin
                        r_acc[m]                <= '0;
                        r_sad[m*SADW +: SADW]   <= w_new_sad[m];
                    end else begin
                        r_acc[m]                <= w_new_sad[m];
                    end
                end
                if (w_last) r_best <= w_best;
            end
        end
    end

    assign out_row   = r_out_row;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign sad       = r_sad;
    assign best_mode = r_best;

endmodule

// File: tb/tb_reser_sad_chroma.sv
// Scoreboard bench for reser_sad_chroma: directed blocks plus randomized rows with backpressure.
module tb_reser_sad_chroma;

    localparam int BLK  = 8;
    localparam int W    = 8;
    localparam int NM   = 4;
    localparam int SADW = 14;
    localparam int ROWB = NM*BLK*(W+1);

    typedef struct packed {
        logic [ROWB-1:0]    row;
        logic [2:0]         idx;
        logic               last;
        logic [NM*SADW-1:0] sad;
        logic [1:0]         best;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [BLK*W-1:0]      mb_row = '0;
    logic [NM*BLK*W-1:0]   pred_row = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [ROWB-1:0]       out_row;
    logic [2:0]            out_idx;
    logic                  out_last;
    logic [NM*SADW-1:0]    sad;
    logic [1:0]            best_mode;

    reser_sad_chroma #(.BLK(BLK), .W(W), .NMODES(NM)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mb_row    (mb_row),
        .pred_row  (pred_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sad       (sad),
        .best_mode (best_mode)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    int   tb_mb [BLK];
    int   tb_pred [NM][BLK];
    int   macc [NM];
    int   mcnt = 0;
    bit   rand_bp = 0;
    int   force_low = 0;
    int   stalls = 0;
    logic [NM*SADW-1:0] cap_sad = '0;
    logic [1:0]         cap_best = '0;
    logic [ROWB-1:0]    cap_row = '0;

    task automatic chk(input string nm, input logic [ROWB-1:0] act, input logic [ROWB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: residual = mb - pred as plain integers; SAD is a running per-mode sum.
    task automatic model_accept();
        exp_t e;
        int   d, rs, bi;
        e = '0;
        e.idx  = 3'(mcnt);
        e.last = (mcnt == BLK-1);
        for (int m = 0; m < NM; m++) begin
            rs = 0;
            for (int l = 0; l < BLK; l++) begin
                d = tb_mb[l] - tb_pred[m][l];
                e.row[(m*BLK+l)*(W+1) +: W+1] = 9'(d);
                rs += (d < 0) ? -d : d;
            end
            macc[m] += rs;
        end
        if (e.last) begin
            bi = 0;
            for (int m = 0; m < NM; m++) begin
                e.sad[m*SADW +: SADW] = 14'(macc[m]);
                if (macc[m] < macc[bi]) bi = m;
            end
            e.best = 2'(bi);
            for (int m = 0; m < NM; m++) macc[m] = 0;
        end
        mcnt = (mcnt + 1) % BLK;
        q.push_back(e);
    endtask

    task automatic send();
        int cyc;
        @(negedge clk);
        for (int l = 0; l < BLK; l++) begin
            mb_row[l*W +: W] = 8'(tb_mb[l]);
            for (int m = 0; m < NM; m++) pred_row[(m*BLK+l)*W +: W] = 8'(tb_pred[m][l]);
        end
        in_valid = 1'b1;
        #1;
        cyc = 0;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        model_accept();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_uniform(input int mbv, input int v, input int h, input int dc, input int pl);
        for (int l = 0; l < BLK; l++) begin
            tb_mb[l]      = mbv;
            tb_pred[0][l] = v;
            tb_pred[1][l] = h;
            tb_pred[2][l] = dc;
            tb_pred[3][l] = pl;
        end
    endtask

    task automatic set_random();
        for (int l = 0; l < BLK; l++) begin
            tb_mb[l] = $urandom_range(0, 255);
            for (int m = 0; m < NM; m++) tb_pred[m][l] = $urandom_range(0, 255);
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (q.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d rows outstanding expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mcnt = 0;
        for (int m = 0; m < NM; m++) macc[m] = 0;
        repeat (3) begin
            mb_row = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) pred_row[i*32 +: 32] = $urandom;
            in_valid = 1'(($urandom & 1));
            @(negedge clk);
        end
        #1;
        chk("rst_out_valid", ROWB'(out_valid), '0);
        chk("rst_out_row",   out_row,          '0);
        chk("rst_out_idx",   ROWB'(out_idx),   '0);
        chk("rst_out_last",  ROWB'(out_last),  '0);
        chk("rst_sad",       ROWB'(sad),       '0);
        chk("rst_best_mode", ROWB'(best_mode), '0);
        chk("rst_in_ready",  ROWB'(in_ready),  ROWB'(1));
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (force_low > 0) begin
                out_ready = 1'b0;
                force_low--;
            end else begin
                out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: sample mid-cycle, after out_ready has settled for the coming edge.
    initial begin
        exp_t            e;
        bit              stalled = 0;
        logic [ROWB-1:0] prev_row = '0;
        logic [2:0]      prev_idx = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("stall_row", out_row, prev_row);
                    chk("stall_idx", ROWB'(out_idx), ROWB'(prev_idx));
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", ROWB'(in_ready), '0);
                    stalls++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_row", ROWB'(out_idx), ROWB'(8));
                    end else begin
                        e = q.pop_front();
                        chk("row",  out_row,         e.row);
                        chk("idx",  ROWB'(out_idx),  ROWB'(e.idx));
                        chk("last", ROWB'(out_last), ROWB'(e.last));
                        if (e.last) begin
                            chk("sad",  ROWB'(sad),       ROWB'(e.sad));
                            chk("best", ROWB'(best_mode), ROWB'(e.best));
                            cap_sad  = sad;
                            cap_best = best_mode;
                            cap_row  = out_row;
                        end
                    end
                end
                stalled  = out_valid && !out_ready;
                prev_row = out_row;
                prev_idx = out_idx;
            end
        end
    end

    initial begin
        for (int m = 0; m < NM; m++) macc[m] = 0;
        do_reset();

        // Full-rate uniform block.
        set_uniform(200, 200, 190, 210, 0);
        repeat (BLK) send();
        wait_drain();
        chk("uniform_sad",  ROWB'(cap_sad), ROWB'({14'd12800, 14'd640, 14'd640, 14'd0}));
        chk("uniform_best", ROWB'(cap_best), '0);
        chk("uniform_res_v",  ROWB'(cap_row[0*BLK*9 +: 9]), ROWB'(9'h000));
        chk("uniform_res_h",  ROWB'(cap_row[1*BLK*9 +: 9]), ROWB'(9'h00A));
        chk("uniform_res_dc", ROWB'(cap_row[2*BLK*9 +: 9]), ROWB'(9'h1F6));
        chk("uniform_res_pl", ROWB'(cap_row[3*BLK*9 +: 9]), ROWB'(9'h0C8));

        // Extremes in both directions.
        set_uniform(0, 255, 255, 255, 255);
        repeat (BLK) send();
        wait_drain();
        chk("neg_extreme_res", ROWB'(cap_row[8:0]), ROWB'(9'h101));
        chk("neg_extreme_sad", ROWB'(cap_sad), ROWB'({4{14'd16320}}));
        set_uniform(255, 0, 0, 0, 0);
        repeat (BLK) send();
        wait_drain();
        chk("pos_extreme_res", ROWB'(cap_row[8:0]), ROWB'(9'h0FF));
        chk("pos_extreme_sad", ROWB'(cap_sad), ROWB'({4{14'd16320}}));

        // Tie-break: then one mode drops just below the others.
        for (int dcv = 100; dcv >= 99; dcv--) begin
            for (int r = 0; r < BLK; r++) begin
                set_uniform(0, 0, 0, 0, 0);
                if (r == 0) begin
                    tb_pred[0][0] = 100;
                    tb_pred[1][0] = 100;
                    tb_pred[2][0] = dcv;
                    tb_pred[3][0] = 255;
                end
                if (r == 1) tb_pred[3][0] = 45;
                send();
            end
            wait_drain();
            chk("tie_sad", ROWB'(cap_sad), ROWB'({14'd300, 14'(dcv), 14'd100, 14'd100}));
            chk("tie_best", ROWB'(cap_best), (dcv == 100) ? ROWB'(0) : ROWB'(2));
        end

        // Backpressure for 3 cycles once row 3 has been accepted.
        stalls = 0;
        set_uniform(200, 200, 190, 210, 0);
        for (int r = 0; r < BLK; r++) begin
            send();
            if (r == 3) force_low = 3;
        end
        wait_drain();
        chk("bp_stall_cycles", ROWB'(stalls >= 3), ROWB'(1));
        chk("bp_sad", ROWB'(cap_sad), ROWB'({14'd12800, 14'd640, 14'd640, 14'd0}));

        // Mid-block reset, leaving one output pending.
        for (int r = 0; r < 5; r++) begin
            set_random();
            send();
        end
        force_low = 2;
        do_reset();
        set_uniform(10, 0, 0, 0, 0);
        repeat (BLK) send();
        wait_drain();
        chk("post_reset_sad_v", ROWB'(cap_sad[13:0]), ROWB'(14'd640));

        // Random blocks with gaps and random backpressure.
        rand_bp = 1;
        for (int b = 0; b < 6; b++) begin
            for (int r = 0; r < BLK; r++) begin
                set_random();
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                send();
            end
        end
        wait_drain();
        rand_bp = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
